// File: rtl/alarm_ctrl_if.sv
// Alarm controller signal bundle: time/alarm digits, controls and status.
interface alarm_ctrl_if;
    logic       sec_tick;
    logic [3:0] hourdec_now;
    logic [3:0] hourone_now;
    logic [3:0] mindec_now;
    logic [3:0] minone_now;
    logic [3:0] hourdec_alm;
    logic [3:0] hourone_alm;
    logic [3:0] mindec_alm;
    logic [3:0] minone_alm;
    logic       set_en;
    logic       arm;
    logic       snooze;
    logic       stop;
    logic       ring;
    logic [1:0] state_o;
    logic [3:0] snooze_left;
    logic       set_err;

    modport master (
        output sec_tick,
        output hourdec_now, hourone_now, mindec_now, minone_now,
        output hourdec_alm, hourone_alm, mindec_alm, minone_alm,
        output set_en, arm, snooze, stop,
        input  ring, state_o, snooze_left, set_err
    );

    modport slave (
        input  sec_tick,
        input  hourdec_now, hourone_now, mindec_now, minone_now,
        input  hourdec_alm, hourone_alm, mindec_alm, minone_alm,
        input  set_en, arm, snooze, stop,
        output ring, state_o, snooze_left, set_err
    );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: validated alarm-time register, rising-edge match
// trigger, ring/snooze state machine with per-event snooze budget.
module alarm_ctrl #(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned MAX_SNOOZE = 3
) (
    input  logic         clk,
    input  logic         rst,
    alarm_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    localparam logic [15:0] LP_RING_LAST   = 16'(RING_SEC - 1);
    localparam logic [15:0] LP_SNOOZE_LAST = 16'(SNOOZE_SEC - 1);
    localparam logic [3:0]  LP_MAX_SNOOZE  = 4'(MAX_SNOOZE);

    state_t      r_state;
    logic [3:0]  r_hourdec_alm;
    logic [3:0]  r_hourone_alm;
    logic [3:0]  r_mindec_alm;
    logic [3:0]  r_minone_alm;
    logic        r_match_q;
    logic [15:0] r_sec_cnt;
    logic [3:0]  r_snooze_left;
    logic        r_set_err;

    logic        w_valid;
    logic        w_match;
    logic        w_trigger;

    // Candidate validation and rising-edge match detection.
    always_comb begin
        w_valid = (bus.hourdec_alm <= 4'd2) &&
                  (bus.hourone_alm <= 4'd9) &&
                  ((bus.hourdec_alm != 4'd2) || (bus.hourone_alm <= 4'd3)) &&
                  (bus.mindec_alm <= 4'd5) &&
                  (bus.minone_alm <= 4'd9);
        w_match = (bus.hourdec_now == r_hourdec_alm) &&
                  (bus.hourone_now == r_hourone_alm) &&
                  (bus.mindec_now  == r_mindec_alm)  &&
                  (bus.minone_now  == r_minone_alm);
        w_trigger = w_match && !r_match_q;
    end

    // Alarm register, match history and ring/snooze state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_hourdec_alm <= '0;
            r_hourone_alm <= '0;
            r_mindec_alm  <= '0;
            r_minone_alm  <= '0;
            r_match_q     <= 1'b1;
            r_sec_cnt     <= '0;
            r_snooze_left <= '0;
            r_set_err     <= 1'b0;
        end else begin
            r_match_q <= w_match;
            r_set_err <= 1'b0;

            if (bus.set_en) begin
                if (w_valid) begin
                    r_hourdec_alm <= bus.hourdec_alm;
                    r_hourone_alm <= bus.hourone_alm;
                    r_mindec_alm  <= bus.mindec_alm;
                    r_minone_alm  <= bus.minone_alm;
                end else begin
                    r_set_err <= 1'b1;
                end
            end

            unique case (r_state)
                IDLE: begin
                    r_sec_cnt <= '0;
                    if (bus.arm) r_state <= ARMED;
                end
                ARMED: begin
                    r_sec_cnt <= '0;
                    if (!bus.arm) begin
                        r_state <= IDLE;
                    end else if (w_trigger) begin
                        r_state       <= RINGING;
                        r_snooze_left <= LP_MAX_SNOOZE;
                    end
                end
                RINGING: begin
                    if (!bus.arm) begin
                        r_state   <= IDLE;
                        r_sec_cnt <= '0;
                    end else if (bus.stop) begin
                        r_state   <= ARMED;
                        r_sec_cnt <= '0;
                    end else if (bus.snooze && (r_snooze_left != 4'd0)) begin
                        r_state       <= SNOOZE;
                        r_sec_cnt     <= '0;
                        r_snooze_left <= r_snooze_left - 4'd1;
                    end else if (bus.sec_tick) begin
                        if (r_sec_cnt == LP_RING_LAST) begin
                            r_state   <= ARMED;
                            r_sec_cnt <= '0;
                        end else begin
                            r_sec_cnt <= r_sec_cnt + 16'd1;
                        end
                    end
                end
                SNOOZE: begin
                    if (!bus.arm) begin
                        r_state   <= IDLE;
                        r_sec_cnt <= '0;
                    end else if (bus.stop) begin
                        r_state   <= ARMED;
                        r_sec_cnt <= '0;
                    end else if (bus.sec_tick) begin
                        if (r_sec_cnt == LP_SNOOZE_LAST) begin
                            r_state   <= RINGING;
                            r_sec_cnt <= '0;
                        end else begin
                            r_sec_cnt <= r_sec_cnt + 16'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ring        = (r_state == RINGING);
    assign bus.state_o     = r_state;
    assign bus.snooze_left = r_snooze_left;
    assign bus.set_err     = r_set_err;
endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed self-checking bench for alarm_ctrl.
module tb_alarm_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    alarm_ctrl_if u_if ();

    alarm_ctrl #(
        .RING_SEC   (60),
        .SNOOZE_SEC (300),
        .MAX_SNOOZE (3)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_now(input logic [3:0] hd, input logic [3:0] ho,
                           input logic [3:0] md, input logic [3:0] mo);
        u_if.hourdec_now = hd;
        u_if.hourone_now = ho;
        u_if.mindec_now  = md;
        u_if.minone_now  = mo;
    endtask

    task automatic set_alm(input logic [3:0] hd, input logic [3:0] ho,
                           input logic [3:0] md, input logic [3:0] mo);
        u_if.hourdec_alm = hd;
        u_if.hourone_alm = ho;
        u_if.mindec_alm  = md;
        u_if.minone_alm  = mo;
        u_if.set_en      = 1'b1;
        step();
        u_if.set_en      = 1'b0;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            u_if.sec_tick = 1'b1;
            step();
            u_if.sec_tick = 1'b0;
        end
    endtask

    task automatic pulse_snooze();
        u_if.snooze = 1'b1;
        step();
        u_if.snooze = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        u_if.sec_tick = 1'b0;
        u_if.set_en   = 1'b0;
        u_if.arm      = 1'b0;
        u_if.snooze   = 1'b0;
        u_if.stop     = 1'b0;
        set_now(4'd0, 4'd7, 4'd2, 4'd9);
        u_if.hourdec_alm = '0;
        u_if.hourone_alm = '0;
        u_if.mindec_alm  = '0;
        u_if.minone_alm  = '0;
        step();
        step();
        check("rst_state",  16'(u_if.state_o), 16'd0);
        check("rst_ring",   16'(u_if.ring), 16'd0);
        check("rst_left",   16'(u_if.snooze_left), 16'd0);
        check("rst_seterr", 16'(u_if.set_err), 16'd0);
        rst = 1'b0;

        // Basic trigger at 07:30.
        set_alm(4'd0, 4'd7, 4'd3, 4'd0);
        check("set0730_err", 16'(u_if.set_err), 16'd0);
        u_if.arm = 1'b1;
        step();
        check("armed", 16'(u_if.state_o), 16'd1);
        set_now(4'd0, 4'd7, 4'd3, 4'd0);
        #1;
        check("ring_before_edge", 16'(u_if.ring), 16'd0);
        step();
        check("ring_up", 16'(u_if.ring), 16'd1);
        check("ring_state", 16'(u_if.state_o), 16'd2);
        check("ring_left", 16'(u_if.snooze_left), 16'd3);

        // Use the whole snooze budget, each pause lasting 300 ticks.
        for (int unsigned s = 0; s < 3; s++) begin
            pulse_snooze();
            check("snz_state", 16'(u_if.state_o), 16'd3);
            check("snz_ring", 16'(u_if.ring), 16'd0);
            check("snz_left", 16'(u_if.snooze_left), 16'(2 - s));
            ticks(299);
            check("snz_299", 16'(u_if.state_o), 16'd3);
            ticks(1);
            check("snz_300_ring", 16'(u_if.ring), 16'd1);
            check("snz_300_state", 16'(u_if.state_o), 16'd2);
        end

        // Budget exhausted: snooze ignored, auto-off after 60 ticks.
        pulse_snooze();
        check("snz_ignored", 16'(u_if.state_o), 16'd2);
        check("snz_ignored_left", 16'(u_if.snooze_left), 16'd0);
        ticks(59);
        check("ring_59", 16'(u_if.state_o), 16'd2);
        ticks(1);
        check("autooff_state", 16'(u_if.state_o), 16'd1);
        check("autooff_ring", 16'(u_if.ring), 16'd0);
        step();
        step();
        step();
        check("no_retrigger", 16'(u_if.state_o), 16'd1);

        // Invalid candidates rejected; alarm stays 07:30.
        set_alm(4'd2, 4'd4, 4'd0, 4'd0);
        check("bad2400_err", 16'(u_if.set_err), 16'd1);
        check("bad2400_state", 16'(u_if.state_o), 16'd1);
        step();
        check("err_clears", 16'(u_if.set_err), 16'd0);
        set_alm(4'd1, 4'd2, 4'd6, 4'd0);
        check("bad1260_err", 16'(u_if.set_err), 16'd1);
        set_now(4'd0, 4'd7, 4'd2, 4'd9);
        step();
        set_now(4'd0, 4'd7, 4'd3, 4'd0);
        step();
        check("alm_kept_ring", 16'(u_if.state_o), 16'd2);
        check("reload_left", 16'(u_if.snooze_left), 16'd3);

        // Invalid set_en while ringing: error pulse, no state change.
        set_alm(4'd2, 4'd4, 4'd0, 4'd0);
        check("set_in_ring_err", 16'(u_if.set_err), 16'd1);
        check("set_in_ring_state", 16'(u_if.state_o), 16'd2);

        // stop beats snooze.
        u_if.stop   = 1'b1;
        u_if.snooze = 1'b1;
        step();
        u_if.stop   = 1'b0;
        u_if.snooze = 1'b0;
        check("stop_over_snz", 16'(u_if.state_o), 16'd1);
        check("stop_left_hold", 16'(u_if.snooze_left), 16'd3);

        // arm=0 beats stop.
        set_now(4'd0, 4'd7, 4'd2, 4'd9);
        step();
        set_now(4'd0, 4'd7, 4'd3, 4'd0);
        step();
        check("ring_again", 16'(u_if.state_o), 16'd2);
        u_if.arm  = 1'b0;
        u_if.stop = 1'b1;
        step();
        u_if.stop = 1'b0;
        check("disarm_over_stop", 16'(u_if.state_o), 16'd0);
        u_if.arm = 1'b1;
        step();
        check("rearm", 16'(u_if.state_o), 16'd1);

        // 23:59 accepted.
        set_alm(4'd2, 4'd3, 4'd5, 4'd9);
        check("set2359_err", 16'(u_if.set_err), 16'd0);
        set_now(4'd2, 4'd3, 4'd5, 4'd8);
        step();
        set_now(4'd2, 4'd3, 4'd5, 4'd9);
        step();
        check("ring_2359", 16'(u_if.state_o), 16'd2);

        // Reset in the middle of a snooze.
        pulse_snooze();
        check("pre_rst_snz", 16'(u_if.state_o), 16'd3);
        set_now(4'd0, 4'd0, 4'd0, 4'd0);
        rst = 1'b1;
        step();
        check("rst_snz_state", 16'(u_if.state_o), 16'd0);
        check("rst_snz_ring", 16'(u_if.ring), 16'd0);
        check("rst_snz_left", 16'(u_if.snooze_left), 16'd0);
        rst = 1'b0;
        step();
        check("post_rst_armed", 16'(u_if.state_o), 16'd1);
        step();
        step();
        check("no_spurious_state", 16'(u_if.state_o), 16'd1);
        check("no_spurious_ring", 16'(u_if.ring), 16'd0);
        set_now(4'd2, 4'd3, 4'd5, 4'd9);
        step();
        set_now(4'd0, 4'd0, 4'd0, 4'd0);
        step();
        check("ring_0000", 16'(u_if.ring), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
